// File: rtl/operand_forward_ctrl.sv
// rtl/operand_forward_ctrl.sv - decode-stage hazard and operand forwarding controller
module operand_forward_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] Ins,
    input  logic        ins_valid,
    output logic [1:0]  mux_sel_a,
    output logic [1:0]  mux_sel_b,
    output logic        Imm_sel,
    output logic        stall,
    output logic [4:0]  RW_dm,
    output logic        wen_dm
);

    typedef struct packed {
        logic       wr;
        logic       ld;
        logic [4:0] rw;
    } stage_t;

    // WB results are already final, so the load flag is not carried there
    typedef struct packed {
        logic       wr;
        logic [4:0] rw;
    } wb_stage_t;

    stage_t    ex_q, ex_d, dm_q, dm_d;
    wb_stage_t wb_q, wb_d;

    logic [4:0] opcode, rw_f, ra_f, rb_f;
    logic       is_rr, is_imm, is_load, is_store;
    logic       reads_a, reads_b, writes;
    logic       hazard;

    assign opcode = Ins[19:15];
    assign rw_f   = Ins[14:10];
    assign ra_f   = Ins[9:5];
    assign rb_f   = Ins[4:0];

    function automatic logic [1:0] fwd_sel(input logic rd, input logic [4:0] src,
                                           input stage_t ex, input stage_t dm,
                                           input wb_stage_t wb);
        logic [1:0] sel;
        sel = 2'b00;
        if (rd) begin
            if (ex.wr && ex.rw == src)
                sel = 2'b01;
            else if (dm.wr && dm.rw == src)
                sel = 2'b10;
            else if (wb.wr && wb.rw == src)
                sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        is_rr    = 1'b0;
        is_imm   = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        if (ins_valid) begin
            is_rr    = (opcode >= 5'd1)  && (opcode <= 5'd15);
            is_imm   = (opcode >= 5'd16) && (opcode <= 5'd23);
            is_load  = (opcode == 5'd24);
            is_store = (opcode == 5'd25);
        end
        reads_a = is_rr | is_imm | is_load | is_store;
        reads_b = is_rr | is_store;
        writes  = is_rr | is_imm | is_load;
    end

    always_comb begin
        mux_sel_a = fwd_sel(reads_a, ra_f, ex_q, dm_q, wb_q);
        mux_sel_b = fwd_sel(reads_b, rb_f, ex_q, dm_q, wb_q);
        Imm_sel   = is_imm;
        hazard    = ins_valid && ex_q.wr && ex_q.ld &&
                    ((reads_a && ex_q.rw == ra_f) || (reads_b && ex_q.rw == rb_f));
        stall     = hazard;
    end

    always_comb begin
        ex_d = '0;
        if (!hazard) begin
            ex_d.wr = writes;
            ex_d.ld = is_load;
            ex_d.rw = writes ? rw_f : 5'd0;
        end
        dm_d    = ex_q;
        wb_d.wr = dm_q.wr;
        wb_d.rw = dm_q.rw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
            dm_q <= '0;
            wb_q <= '0;
        end else begin
            ex_q <= ex_d;
            dm_q <= dm_d;
            wb_q <= wb_d;
        end
    end

    assign RW_dm  = dm_q.rw;
    assign wen_dm = dm_q.wr;

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// tb/tb_operand_forward_ctrl.sv - directed self-checking bench for operand_forward_ctrl
module tb_operand_forward_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] Ins;
    logic        ins_valid;
    logic [1:0]  mux_sel_a, mux_sel_b;
    logic        Imm_sel, stall;
    logic [4:0]  RW_dm;
    logic        wen_dm;

    int checks = 0;
    int failures = 0;

    localparam logic [4:0] OP_NOP = 5'd0, OP_ADD = 5'd1, OP_ADDI = 5'd16,
                           OP_LOAD = 5'd24, OP_STORE = 5'd25, OP_RSVD = 5'd26;

    always #5 clk = ~clk;

    operand_forward_ctrl dut (
        .clk(clk), .rst(rst), .Ins(Ins), .ins_valid(ins_valid),
        .mux_sel_a(mux_sel_a), .mux_sel_b(mux_sel_b), .Imm_sel(Imm_sel),
        .stall(stall), .RW_dm(RW_dm), .wen_dm(wen_dm)
    );

    // {stall, Imm_sel, mux_sel_a, mux_sel_b}
    logic [5:0] outs;
    assign outs = {stall, Imm_sel, mux_sel_a, mux_sel_b};

    function automatic logic [19:0] mk(input logic [4:0] op, input logic [4:0] rw,
                                       input logic [4:0] ra, input logic [4:0] rb);
        return {op, rw, ra, rb};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        Ins = mk(OP_NOP, 0, 0, 0);
        ins_valid = 1'b1;
        repeat (3) cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ins_valid = 1'b1;
        Ins = mk(OP_ADD, 5, 1, 2);
        repeat (2) cyc();
        checks++;
        if ({wen_dm, RW_dm} !== 6'b0) begin
            failures++;
            $display("FAIL reset_dm got wen=%b rw=%0d exp wen=0 rw=0", wen_dm, RW_dm);
        end
        rst = 1'b0;
        Ins = mk(OP_NOP, 0, 0, 0);
        #1;
        checks++;
        if (outs !== 6'b000000) begin
            failures++;
            $display("FAIL reset_nop_outs got=%b exp=000000", outs);
        end
    endtask

    task automatic test_ex_forward();
        flush();
        Ins = mk(OP_ADD, 5, 1, 2);
        cyc();
        Ins = mk(OP_ADD, 6, 5, 3);
        #1;
        checks++;
        if (outs !== 6'b000100) begin
            failures++;
            $display("FAIL ex_fwd got=%b exp=000100", outs);
        end
        cyc();
        checks++;
        if ({wen_dm, RW_dm} !== {1'b1, 5'd5}) begin
            failures++;
            $display("FAIL ex_fwd_dm got wen=%b rw=%0d exp wen=1 rw=5", wen_dm, RW_dm);
        end
        flush();
        Ins = mk(OP_ADD, 0, 1, 2);
        cyc();
        Ins = mk(OP_ADD, 1, 0, 0);
        #1;
        checks++;
        if (outs !== 6'b000101) begin
            failures++;
            $display("FAIL r0_same_src got=%b exp=000101", outs);
        end
        cyc();
    endtask

    task automatic test_dm_wb_forward();
        flush();
        Ins = mk(OP_ADD, 7, 1, 2);
        cyc();
        Ins = mk(OP_NOP, 0, 0, 0);
        cyc();
        Ins = mk(OP_ADD, 8, 1, 7);
        #1;
        checks++;
        if (outs !== 6'b000010) begin
            failures++;
            $display("FAIL dm_fwd got=%b exp=000010", outs);
        end
        flush();
        Ins = mk(OP_ADD, 7, 1, 2);
        cyc();
        Ins = mk(OP_NOP, 0, 0, 0);
        repeat (2) cyc();
        Ins = mk(OP_ADD, 8, 1, 7);
        #1;
        checks++;
        if (outs !== 6'b000011) begin
            failures++;
            $display("FAIL wb_fwd got=%b exp=000011", outs);
        end
        cyc();
    endtask

    task automatic test_priority();
        flush();
        Ins = mk(OP_ADD, 4, 1, 2);
        cyc();
        Ins = mk(OP_ADD, 4, 1, 3);
        cyc();
        Ins = mk(OP_ADD, 9, 4, 0);
        #1;
        checks++;
        if (outs !== 6'b000100) begin
            failures++;
            $display("FAIL priority got=%b exp=000100", outs);
        end
        Ins = mk(OP_ADD, 4, 4, 4);
        #1;
        checks++;
        if (outs !== 6'b000101) begin
            failures++;
            $display("FAIL own_rw_only_older got=%b exp=000101", outs);
        end
        Ins = mk(OP_RSVD, 4, 4, 4);
        #1;
        checks++;
        if (outs !== 6'b000000) begin
            failures++;
            $display("FAIL reserved_nop got=%b exp=000000", outs);
        end
        cyc();
    endtask

    task automatic test_load_use();
        flush();
        Ins = mk(OP_LOAD, 9, 1, 0);
        cyc();
        Ins = mk(OP_ADD, 10, 9, 9);
        #1;
        checks++;
        if (outs !== 6'b100101) begin
            failures++;
            $display("FAIL load_use_stall got=%b exp=100101", outs);
        end
        cyc();
        checks++;
        if ({wen_dm, RW_dm} !== {1'b1, 5'd9}) begin
            failures++;
            $display("FAIL load_dm got wen=%b rw=%0d exp wen=1 rw=9", wen_dm, RW_dm);
        end
        checks++;
        if (outs !== 6'b001010) begin
            failures++;
            $display("FAIL load_use_resolve got=%b exp=001010", outs);
        end
        cyc();
        Ins = mk(OP_ADD, 11, 9, 1);
        #1;
        checks++;
        if (outs !== 6'b001100) begin
            failures++;
            $display("FAIL back_to_back got=%b exp=001100", outs);
        end
        cyc();
        flush();
        Ins = mk(OP_LOAD, 9, 1, 0);
        cyc();
        Ins = mk(OP_ADD, 10, 9, 9);
        ins_valid = 1'b0;
        #1;
        checks++;
        if (outs !== 6'b000000) begin
            failures++;
            $display("FAIL invalid_no_stall got=%b exp=000000", outs);
        end
        ins_valid = 1'b1;
        flush();
        Ins = mk(OP_LOAD, 12, 1, 0);
        cyc();
        Ins = mk(OP_STORE, 0, 2, 12);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL store_b_stall got=%b exp=1", stall);
        end
        cyc();
    endtask

    task automatic test_imm_store();
        flush();
        Ins = mk(OP_ADD, 3, 1, 2);
        cyc();
        Ins = mk(OP_ADDI, 4, 3, 3);
        #1;
        checks++;
        if (outs !== 6'b010100) begin
            failures++;
            $display("FAIL imm_fwd got=%b exp=010100", outs);
        end
        cyc();
        Ins = mk(OP_STORE, 5, 1, 2);
        cyc();
        checks++;
        if ({wen_dm, RW_dm} !== {1'b1, 5'd4}) begin
            failures++;
            $display("FAIL addi_dm got wen=%b rw=%0d exp wen=1 rw=4", wen_dm, RW_dm);
        end
        Ins = mk(OP_NOP, 0, 0, 0);
        cyc();
        checks++;
        if (wen_dm !== 1'b0) begin
            failures++;
            $display("FAIL store_no_wen got=%b exp=0", wen_dm);
        end
    endtask

    task automatic test_reset_during_stall();
        flush();
        Ins = mk(OP_LOAD, 9, 1, 0);
        cyc();
        Ins = mk(OP_ADD, 10, 9, 9);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_stall got=%b exp=1", stall);
        end
        rst = 1'b1;
        cyc();
        checks++;
        if ({stall, wen_dm, RW_dm} !== 7'b0) begin
            failures++;
            $display("FAIL reset_clears_stall got stall=%b wen=%b rw=%0d exp 0 0 0",
                     stall, wen_dm, RW_dm);
        end
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        ins_valid = 1'b0;
        Ins = '0;
        test_reset();
        test_ex_forward();
        test_dm_wb_forward();
        test_priority();
        test_load_use();
        test_imm_store();
        test_reset_during_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
